// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: forwarding selects and hazard-unit FSM states.
package cpu_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// One EX-stage operand forwarding select: the youngest in-flight writer of src wins.
import cpu_pkg::*;

module hazard_fwd_sel #(
  parameter int REG_IDX_W = 5
) (
  input  logic [REG_IDX_W-1:0] src,
  input  logic [REG_IDX_W-1:0] write_reg_m,
  input  logic                 reg_write_m,
  input  logic [REG_IDX_W-1:0] write_reg_w,
  input  logic                 reg_write_w,
  output fwd_sel_t             sel
);

  logic src_nz_s;

  assign src_nz_s = (src != {REG_IDX_W{1'b0}});

  // M beats W; $0 never forwards
  always_comb begin
    sel = FWD_NONE;
    if (src_nz_s && reg_write_m && (write_reg_m == src)) begin
      sel = FWD_MEM;
    end else if (src_nz_s && reg_write_w && (write_reg_w == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_NONE;
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline: forwarding selects, stall/flush,
// data-memory freeze FSM with timeout, and saturating stall/flush performance counters.
import cpu_pkg::*;

module pipeline_hazard_unit #(
  parameter int REG_IDX_W = 5,
  parameter int CNT_W     = 16,
  parameter int MEM_TMO   = 255,
  parameter int FWD_ID_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rs_d,
  input  logic [REG_IDX_W-1:0] rt_d,
  input  logic                 branch_d,
  input  logic                 pc_src_d,
  input  logic [REG_IDX_W-1:0] rs_e,
  input  logic [REG_IDX_W-1:0] rt_e,
  input  logic [REG_IDX_W-1:0] write_reg_e,
  input  logic [REG_IDX_W-1:0] write_reg_m,
  input  logic [REG_IDX_W-1:0] write_reg_w,
  input  logic                 reg_write_e,
  input  logic                 reg_write_m,
  input  logic                 reg_write_w,
  input  logic                 mem_to_reg_e,
  input  logic                 mem_to_reg_m,
  input  logic                 mem_req_m,
  input  logic                 mem_ready,
  output logic [1:0]           fwd_a_e,
  output logic [1:0]           fwd_b_e,
  output logic                 fwd_a_d,
  output logic                 fwd_b_d,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 stall_e,
  output logic                 stall_m,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic                 flush_w,
  output logic                 hazard_detected,
  output logic                 mem_timeout,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_count
);

  localparam int              WAIT_W = $clog2(MEM_TMO + 1);
  localparam logic [WAIT_W-1:0] TMO_C = WAIT_W'(MEM_TMO);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  function automatic logic idx_hit(input logic [REG_IDX_W-1:0] a, input logic [REG_IDX_W-1:0] b);
    return (a != {REG_IDX_W{1'b0}}) && (a == b);
  endfunction

  hz_state_t         state_r, next_state_s;
  fwd_sel_t          fwd_a_sel_s, fwd_b_sel_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              mem_timeout_r;
  logic [CNT_W-1:0]  stall_cycles_r, flush_count_r;
  logic              load_use_s, br_haz_s, hit_e_s, hit_m_s, wait_inc_s;
  logic              stall_f_s, stall_d_s, stall_e_s, stall_m_s;
  logic              flush_d_s, flush_e_s, flush_w_s, any_stall_s, any_flush_s;

  hazard_fwd_sel #(.REG_IDX_W(REG_IDX_W)) u_fwd_a (
    .src(rs_e), .write_reg_m(write_reg_m), .reg_write_m(reg_write_m),
    .write_reg_w(write_reg_w), .reg_write_w(reg_write_w), .sel(fwd_a_sel_s)
  );

  hazard_fwd_sel #(.REG_IDX_W(REG_IDX_W)) u_fwd_b (
    .src(rt_e), .write_reg_m(write_reg_m), .reg_write_m(reg_write_m),
    .write_reg_w(write_reg_w), .reg_write_w(reg_write_w), .sel(fwd_b_sel_s)
  );

  assign hit_e_s    = idx_hit(write_reg_e, rs_d) || idx_hit(write_reg_e, rt_d);
  assign hit_m_s    = idx_hit(write_reg_m, rs_d) || idx_hit(write_reg_m, rt_d);
  assign load_use_s = mem_to_reg_e && (idx_hit(rt_e, rs_d) || idx_hit(rt_e, rt_d));
  // Without ID forwarding an ALU result sitting in M must also stall the branch
  assign br_haz_s   = branch_d && ((reg_write_e && hit_e_s) || (mem_to_reg_m && hit_m_s) ||
                                   ((FWD_ID_EN == 0) && reg_write_m && hit_m_s));

  // Next state and stall/flush decode; reset forces every control output low at once
  always_comb begin
    next_state_s = state_r;
    stall_f_s    = 1'b0;
    stall_d_s    = 1'b0;
    stall_e_s    = 1'b0;
    stall_m_s    = 1'b0;
    flush_d_s    = 1'b0;
    flush_e_s    = 1'b0;
    flush_w_s    = 1'b0;
    if (rst) begin
      next_state_s = RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (mem_req_m && !mem_ready) begin
            next_state_s = MEM_WAIT;
            {stall_f_s, stall_d_s, stall_e_s, stall_m_s, flush_w_s} = 5'b11111;
          end else if (load_use_s || br_haz_s) begin
            {stall_f_s, stall_d_s, flush_e_s} = 3'b111;
          end else if (pc_src_d) begin
            flush_d_s = 1'b1;
          end else begin
            next_state_s = RUN;
          end
        end
        MEM_WAIT: begin
          {stall_f_s, stall_d_s, stall_e_s, stall_m_s, flush_w_s} = 5'b11111;
          if (mem_ready) begin
            next_state_s = RUN;
          end else begin
            next_state_s = MEM_WAIT;
          end
        end
        default: begin
          next_state_s = RUN;
        end
      endcase
    end
  end

  assign any_stall_s = stall_f_s | stall_d_s | stall_e_s | stall_m_s;
  assign any_flush_s = flush_d_s | flush_e_s | flush_w_s;
  assign wait_inc_s  = (state_r == MEM_WAIT) && !mem_ready;

  // FSM state, wait counter and sticky timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= RUN;
      wait_cnt_r    <= {WAIT_W{1'b0}};
      mem_timeout_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (wait_inc_s) begin
        if (wait_cnt_r != TMO_C) begin
          wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end
        if (wait_cnt_r == TMO_C - WAIT_W'(1)) begin
          mem_timeout_r <= 1'b1;
        end
      end else begin
        wait_cnt_r <= {WAIT_W{1'b0}};
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_r <= {CNT_W{1'b0}};
      flush_count_r  <= {CNT_W{1'b0}};
    end else begin
      if (any_stall_s && (stall_cycles_r != CNT_MAX)) begin
        stall_cycles_r <= stall_cycles_r + CNT_W'(1);
      end
      if (any_flush_s && (flush_count_r != CNT_MAX)) begin
        flush_count_r <= flush_count_r + CNT_W'(1);
      end
    end
  end

  assign fwd_a_e = rst ? 2'b00 : fwd_a_sel_s;
  assign fwd_b_e = rst ? 2'b00 : fwd_b_sel_s;
  assign fwd_a_d = !rst && (FWD_ID_EN != 0) && reg_write_m && !mem_to_reg_m && idx_hit(write_reg_m, rs_d);
  assign fwd_b_d = !rst && (FWD_ID_EN != 0) && reg_write_m && !mem_to_reg_m && idx_hit(write_reg_m, rt_d);

  assign stall_f         = stall_f_s;
  assign stall_d         = stall_d_s;
  assign stall_e         = stall_e_s;
  assign stall_m         = stall_m_s;
  assign flush_d         = flush_d_s;
  assign flush_e         = flush_e_s;
  assign flush_w         = flush_w_s;
  assign hazard_detected = any_stall_s;
  assign mem_timeout     = mem_timeout_r;
  assign stall_cycles    = stall_cycles_r;
  assign flush_count     = flush_count_r;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed-vector bench for pipeline_hazard_unit with hand-computed expectations.
module tb_pipeline_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic       branch_d, pc_src_d, reg_write_e, reg_write_m, reg_write_w;
  logic       mem_to_reg_e, mem_to_reg_m, mem_req_m, mem_ready;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       fwd_a_d, fwd_b_d, stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w, hazard_detected, mem_timeout;
  logic [15:0] stall_cycles, flush_count;

  int n_chk  = 0;
  int n_pass = 0;

  pipeline_hazard_unit #(.REG_IDX_W(5), .CNT_W(16), .MEM_TMO(4), .FWD_ID_EN(1)) dut (
    .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d), .pc_src_d(pc_src_d),
    .rs_e(rs_e), .rt_e(rt_e), .write_reg_e(write_reg_e), .write_reg_m(write_reg_m),
    .write_reg_w(write_reg_w), .reg_write_e(reg_write_e), .reg_write_m(reg_write_m),
    .reg_write_w(reg_write_w), .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
    .mem_req_m(mem_req_m), .mem_ready(mem_ready), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .stall_f(stall_f), .stall_d(stall_d),
    .stall_e(stall_e), .stall_m(stall_m), .flush_d(flush_d), .flush_e(flush_e),
    .flush_w(flush_w), .hazard_detected(hazard_detected), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    {rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w} = '0;
    {branch_d, pc_src_d, reg_write_e, reg_write_m, reg_write_w} = '0;
    {mem_to_reg_e, mem_to_reg_m, mem_req_m, mem_ready} = '0;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    tick();
    tick();
    chk("rst_stall", {stall_f, stall_d, stall_e, stall_m, hazard_detected}, 0);
    chk("rst_flush", {flush_d, flush_e, flush_w}, 0);
    chk("rst_cnt", {stall_cycles, flush_count}, 0);
    chk("rst_tmo", mem_timeout, 0);
    rst = 1'b0;

    // lw $2 in EX, add $2,$5 in ID
    mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 2; rt_e = 2; rs_d = 2; rt_d = 5;
    #1;
    chk("lu_stall", {stall_f, stall_d, flush_e, hazard_detected}, 4'b1111);
    chk("lu_nostall_em", {stall_e, stall_m, flush_d}, 0);
    tick();
    clear_in();
    reg_write_m = 1; write_reg_m = 2; mem_to_reg_m = 1; mem_req_m = 1; mem_ready = 1;
    rs_e = 2; rt_e = 5; rs_d = 7; rt_d = 8;
    #1;
    chk("lu_fwd_a", fwd_a_e, 2'b10);
    chk("lu_fwd_b", fwd_b_e, 2'b00);
    chk("zero_lat_mem", {stall_f, stall_m, hazard_detected}, 0);
    chk("lu_counts", {stall_cycles, flush_count}, {16'd1, 16'd1});

    // EX forwarding priority and $0
    clear_in();
    rs_e = 3; rt_e = 9; reg_write_m = 1; write_reg_m = 3; reg_write_w = 1; write_reg_w = 3;
    #1;
    chk("fwd_m_wins", fwd_a_e, 2'b10);
    write_reg_w = 9;
    #1;
    chk("fwd_m_w_split", {fwd_a_e, fwd_b_e}, 4'b1001);
    reg_write_m = 0; write_reg_w = 3;
    #1;
    chk("fwd_w_only", fwd_a_e, 2'b01);
    rs_e = 0; reg_write_m = 1; write_reg_m = 0; write_reg_w = 0;
    #1;
    chk("fwd_zero_reg", {fwd_a_e, fwd_b_e}, 0);
    tick();

    // beq $4,$6 with add $4 in EX
    clear_in();
    branch_d = 1; rs_d = 4; rt_d = 6; reg_write_e = 1; write_reg_e = 4;
    #1;
    chk("br_stall", {stall_f, stall_d, flush_e}, 3'b111);
    tick();
    clear_in();
    branch_d = 1; pc_src_d = 1; rs_d = 4; rt_d = 6; reg_write_m = 1; write_reg_m = 4;
    #1;
    chk("br_fwd_d", {stall_d, fwd_a_d, fwd_b_d}, 3'b010);
    chk("br_taken_flush", flush_d, 1);
    tick();

    // beq $4 after lw $4: two stall cycles
    clear_in();
    branch_d = 1; rs_d = 4; rt_d = 6; mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 4; rt_e = 4;
    #1;
    chk("brlw_stall1", stall_d, 1);
    tick();
    clear_in();
    branch_d = 1; rs_d = 4; rt_d = 6; mem_to_reg_m = 1; reg_write_m = 1; write_reg_m = 4;
    #1;
    chk("brlw_stall2", {stall_d, fwd_a_d}, 2'b10);
    tick();
    clear_in();
    branch_d = 1; rs_d = 4; rt_d = 6; reg_write_w = 1; write_reg_w = 4;
    #1;
    chk("brlw_release", stall_d, 0);

    // multi-cycle memory access, ready after 3 low cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_in();
    mem_req_m = 1; mem_ready = 0;
    pc_src_d = 1; mem_to_reg_e = 1; rt_e = 5; rs_d = 5;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1;
      #1;
      chk("mw_freeze", {stall_f, stall_d, stall_e, stall_m, flush_w}, 5'b11111);
      chk("mw_no_df", {flush_d, flush_e}, 0);
      tick();
    end
    clear_in();
    #1;
    chk("mw_run", {stall_m, flush_w, hazard_detected}, 0);
    chk("mw_counts", {stall_cycles, flush_count}, {16'd4, 16'd4});
    chk("mw_no_tmo", mem_timeout, 0);

    // timeout with MEM_TMO=4
    mem_req_m = 1; mem_ready = 0;
    tick();
    chk("tmo_early", mem_timeout, 0);
    for (int i = 0; i < 9; i++) tick();
    chk("tmo_set", {mem_timeout, stall_m}, 2'b11);
    mem_ready = 1;
    tick();
    clear_in();
    #1;
    chk("tmo_sticky", {mem_timeout, stall_m}, 2'b10);

    // reset in the middle of a freeze
    mem_req_m = 1; mem_ready = 0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_out", {stall_f, stall_m, flush_w, hazard_detected}, 0);
    chk("rst_mid_regs", {mem_timeout, stall_cycles, flush_count}, 0);
    clear_in();
    #1;
    rst = 1'b0;

    // taken branch without hazard
    tick();
    branch_d = 1; pc_src_d = 1; rs_d = 4; rt_d = 6;
    #1;
    chk("taken_flush", {flush_d, stall_d, flush_e}, 3'b100);
    tick();
    clear_in();
    #1;
    chk("taken_count", {flush_count, stall_cycles}, {16'd1, 16'd0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
